// File: rtl/rob_pkg.sv
// Shared types and sizing for the reorder buffer and its lookup helper.
package rob_pkg;
  localparam int ROB_DEPTH = 8;
  localparam int ROB_TAG_W = 3;
  localparam int REG_W     = 5;
  localparam int DATA_W    = 32;

  typedef struct packed {
    logic              busy;
    logic              done;
    logic              regwrite;
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] value;
  } rob_entry_t;
endpackage

// File: rtl/rob_youngest_match.sv
// Youngest-writer search for operand lookup; only built when ROB_FWD_EN is defined.
`ifdef ROB_FWD_EN
module rob_youngest_match
  import rob_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH,
  parameter int TAG_W = ROB_TAG_W
) (
  input  logic [DEPTH-1:0] match,
  input  logic [TAG_W-1:0] base,
  output logic             hit,
  output logic [TAG_W-1:0] idx
);

  logic [TAG_W-1:0] pos;

  // Walk from the tail (oldest slot when full) towards tail-1; the last hit is the youngest.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    pos = '0;
    for (int k = 0; k < DEPTH; k++) begin
      pos = base + TAG_W'(k);
      if (match[pos]) begin
        hit = 1'b1;
        idx = pos;
      end
    end
  end

endmodule
`endif

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: dispatch allocates at tail, writeback by tag, commit from head.
// Optional operand lookup port enabled by defining ROB_FWD_EN.
module reorder_buffer
  import rob_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH,
  parameter int TAG_W = ROB_TAG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_valid,
  output logic              disp_ready,
  input  logic              disp_regwrite,
  input  logic [REG_W-1:0]  disp_dest,
  input  logic [DATA_W-1:0] disp_pc,
  output logic [TAG_W-1:0]  disp_tag,
  input  logic              wb_valid,
  input  logic [TAG_W-1:0]  wb_tag,
  input  logic [DATA_W-1:0] wb_value,
  output logic              cm_valid,
  output logic              cm_regwrite,
  output logic [REG_W-1:0]  cm_dest,
  output logic [DATA_W-1:0] cm_value,
  output logic [DATA_W-1:0] cm_pc
`ifdef ROB_FWD_EN
  ,
  input  logic [REG_W-1:0]  lk_addr,
  output logic              lk_hit,
  output logic [TAG_W-1:0]  lk_tag,
  output logic              lk_ready,
  output logic [DATA_W-1:0] lk_value
`endif
);

  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  done_q;
  logic [TAG_W-1:0]  head_q;
  logic [TAG_W-1:0]  tail_q;
  logic [TAG_W:0]    count_q;

  logic              regwrite_q [DEPTH];
  logic [REG_W-1:0]  dest_q     [DEPTH];
  logic [DATA_W-1:0] pc_q       [DEPTH];
  logic [DATA_W-1:0] value_q    [DEPTH];

  rob_entry_t head_ent;
  logic       do_disp;
  logic       do_wb;
  logic       do_cm;

  always_comb begin
    head_ent.busy     = busy_q[head_q];
    head_ent.done     = done_q[head_q];
    head_ent.regwrite = regwrite_q[head_q];
    head_ent.dest     = dest_q[head_q];
    head_ent.pc       = pc_q[head_q];
    head_ent.value    = value_q[head_q];
  end

  // A slot freed by this cycle's commit is not reusable until the next cycle.
  assign disp_ready = (count_q != (TAG_W+1)'(DEPTH));
  assign disp_tag   = tail_q;
  assign do_disp    = disp_valid && disp_ready;
  assign do_wb      = wb_valid && busy_q[wb_tag] && !done_q[wb_tag];
  assign do_cm      = head_ent.busy && head_ent.done;

  assign cm_valid    = do_cm;
  assign cm_regwrite = do_cm && head_ent.regwrite;
  assign cm_dest     = do_cm ? head_ent.dest  : '0;
  assign cm_pc       = do_cm ? head_ent.pc    : '0;
  assign cm_value    = do_cm ? head_ent.value : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q  <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_disp) begin
        busy_q[tail_q] <= 1'b1;
        done_q[tail_q] <= 1'b0;
        tail_q         <= tail_q + 1'b1;
      end
      if (do_wb) begin
        done_q[wb_tag] <= 1'b1;
      end
      if (do_cm) begin
        busy_q[head_q] <= 1'b0;
        done_q[head_q] <= 1'b0;
        head_q         <= head_q + 1'b1;
      end
      count_q <= count_q + (TAG_W+1)'(do_disp) - (TAG_W+1)'(do_cm);
    end
  end

  // Payload is qualified by busy/done, so it needs no reset.
  always_ff @(posedge clk) begin
    if (do_disp) begin
      regwrite_q[tail_q] <= disp_regwrite && (disp_dest != '0);
      dest_q[tail_q]     <= disp_dest;
      pc_q[tail_q]       <= disp_pc;
    end
    if (do_wb) begin
      value_q[wb_tag] <= wb_value;
    end
  end

`ifdef ROB_FWD_EN
  logic [DEPTH-1:0] lk_match;
  logic             lk_found;
  logic [TAG_W-1:0] lk_idx;

  always_comb begin
    lk_match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      lk_match[i] = busy_q[i] && regwrite_q[i] && (dest_q[i] == lk_addr) && (lk_addr != '0);
    end
  end

  rob_youngest_match #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) u_youngest_match (
    .match (lk_match),
    .base  (tail_q),
    .hit   (lk_found),
    .idx   (lk_idx)
  );

  assign lk_hit   = lk_found;
  assign lk_tag   = lk_found ? lk_idx : '0;
  assign lk_ready = lk_found && done_q[lk_idx];
  assign lk_value = lk_ready ? value_q[lk_idx] : '0;
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Randomized scoreboard bench for reorder_buffer; lookup checks enabled with ROB_FWD_EN.
module tb_reorder_buffer;
  localparam int DEPTH = 8;
  localparam int TAG_W = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        disp_valid;
  logic        disp_ready;
  logic        disp_regwrite;
  logic [4:0]  disp_dest;
  logic [31:0] disp_pc;
  logic [2:0]  disp_tag;
  logic        wb_valid;
  logic [2:0]  wb_tag;
  logic [31:0] wb_value;
  logic        cm_valid;
  logic        cm_regwrite;
  logic [4:0]  cm_dest;
  logic [31:0] cm_value;
  logic [31:0] cm_pc;
`ifdef ROB_FWD_EN
  logic [4:0]  lk_addr;
  logic        lk_hit;
  logic [2:0]  lk_tag;
  logic        lk_ready;
  logic [31:0] lk_value;
`endif

  reorder_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .disp_valid    (disp_valid),
    .disp_ready    (disp_ready),
    .disp_regwrite (disp_regwrite),
    .disp_dest     (disp_dest),
    .disp_pc       (disp_pc),
    .disp_tag      (disp_tag),
    .wb_valid      (wb_valid),
    .wb_tag        (wb_tag),
    .wb_value      (wb_value),
    .cm_valid      (cm_valid),
    .cm_regwrite   (cm_regwrite),
    .cm_dest       (cm_dest),
    .cm_value      (cm_value),
    .cm_pc         (cm_pc)
`ifdef ROB_FWD_EN
    ,
    .lk_addr       (lk_addr),
    .lk_hit        (lk_hit),
    .lk_tag        (lk_tag),
    .lk_ready      (lk_ready),
    .lk_value      (lk_value)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    logic [31:0] pc;
    logic        regwrite;
    logic [4:0]  dest;
    logic [31:0] value;
    logic        done;
  } instr_t;

  instr_t q[$];
  int     next_tag = 0;
  int     checks = 0;
  int     errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor/scoreboard: compare outputs of the current state, then advance the model
  // by the transitions the next rising edge will perform.
  always @(negedge clk) begin
    if (!rst) begin
      q.delete();
      next_tag = 0;
      chk("rst_cm_valid", 32'(cm_valid), 32'd0);
      chk("rst_disp_ready", 32'(disp_ready), 32'd1);
      chk("rst_disp_tag", 32'(disp_tag), 32'd0);
      chk("rst_cm_pc", cm_pc, 32'd0);
`ifdef ROB_FWD_EN
      chk("rst_lk_hit", 32'(lk_hit), 32'd0);
      chk("rst_lk_tag", 32'(lk_tag), 32'd0);
      chk("rst_lk_ready", 32'(lk_ready), 32'd0);
      chk("rst_lk_value", lk_value, 32'd0);
`endif
    end else begin
      logic exp_cm;
      logic exp_rdy;
      exp_cm  = (q.size() > 0) && q[0].done;
      exp_rdy = (q.size() < DEPTH);
      chk("cm_valid", 32'(cm_valid), 32'(exp_cm));
      chk("disp_ready", 32'(disp_ready), 32'(exp_rdy));
      chk("disp_tag", 32'(disp_tag), 32'(next_tag));
      if (cm_valid && q.size() > 0) begin
        chk("cm_pc", cm_pc, q[0].pc);
        chk("cm_value", cm_value, q[0].value);
        chk("cm_regwrite", 32'(cm_regwrite), 32'(q[0].regwrite));
        chk("cm_dest", 32'(cm_dest), 32'(q[0].dest));
      end else if (!cm_valid) begin
        chk("idle_cm_fields", {cm_pc ^ cm_value, 26'(cm_dest), cm_regwrite}, 59'd0 >> 27);
      end
`ifdef ROB_FWD_EN
      begin
        logic        h;
        int          t;
        logic        r;
        logic [31:0] v;
        h = 1'b0; t = 0; r = 1'b0; v = 32'd0;
        for (int i = q.size() - 1; i >= 0; i--) begin
          if (!h && lk_addr != 5'd0 && q[i].regwrite && q[i].dest == lk_addr) begin
            h = 1'b1;
            t = q[i].tag;
            r = q[i].done;
            v = q[i].done ? q[i].value : 32'd0;
          end
        end
        chk("lk_hit", 32'(lk_hit), 32'(h));
        chk("lk_tag", 32'(lk_tag), 32'(t));
        chk("lk_ready", 32'(lk_ready), 32'(r));
        if (r) chk("lk_value", lk_value, v);
      end
`endif
      if (exp_cm) void'(q.pop_front());
      if (wb_valid) begin
        foreach (q[i]) begin
          if (q[i].tag == int'(wb_tag) && !q[i].done) begin
            q[i].done  = 1'b1;
            q[i].value = wb_value;
          end
        end
      end
      if (disp_valid && exp_rdy) begin
        instr_t e;
        e.tag      = next_tag;
        e.pc       = disp_pc;
        e.regwrite = disp_regwrite && (disp_dest != 5'd0);
        e.dest     = disp_dest;
        e.value    = 32'd0;
        e.done     = 1'b0;
        q.push_back(e);
        next_tag = (next_tag + 1) % DEPTH;
      end
    end
  end

  task automatic drive(input logic dv, input logic rw, input logic [4:0] dst, input logic [31:0] pc,
                       input logic wv, input logic [2:0] wt, input logic [31:0] wval);
    disp_valid    = dv;
    disp_regwrite = rw;
    disp_dest     = dst;
    disp_pc       = pc;
    wb_valid      = wv;
    wb_tag        = wt;
    wb_value      = wval;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 5'd0, 32'd0, 0, 3'd0, 32'd0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    for (int i = 0; i < n; i++) drive(1, 1, 5'd3, 32'hdead_0000, 1, 3'd0, 32'h1);
    rst = 1'b1;
    idle(1);
  endtask

  initial begin
    rst = 1'b0;
    disp_valid = 0; disp_regwrite = 0; disp_dest = 0; disp_pc = 0;
    wb_valid = 0; wb_tag = 0; wb_value = 0;
`ifdef ROB_FWD_EN
    lk_addr = 5'd0;
`endif
    // Reset held with dispatch asserted: nothing may be allocated.
    do_reset(3);

    // In-order retirement with out-of-order completion.
    drive(1, 1, 5'd1, 32'h00, 0, 3'd0, 32'd0);
    drive(1, 1, 5'd2, 32'h04, 0, 3'd0, 32'd0);
    drive(1, 1, 5'd3, 32'h08, 0, 3'd0, 32'd0);
    drive(0, 0, 5'd0, 32'd0, 1, 3'd2, 32'h33);
    idle(2);
    drive(0, 0, 5'd0, 32'd0, 1, 3'd0, 32'h11);
    drive(0, 0, 5'd0, 32'd0, 1, 3'd1, 32'h22);
    idle(4);

    // Fill, commit-with-refused-dispatch, then wrap to tag 0.
    do_reset(1);
    for (int i = 0; i < DEPTH; i++) drive(1, 1, 5'(i + 1), 32'h100 + 32'(4 * i), 0, 3'd0, 32'd0);
    drive(1, 1, 5'd9, 32'h1ff, 0, 3'd0, 32'd0);
    drive(0, 0, 5'd0, 32'd0, 1, 3'd0, 32'haa);
    drive(1, 1, 5'd9, 32'h200, 0, 3'd0, 32'd0);
    drive(1, 1, 5'd10, 32'h204, 0, 3'd0, 32'd0);
    idle(2);

    // r0 destination and writeback to a freed tag.
    do_reset(1);
    drive(1, 1, 5'd0, 32'h300, 0, 3'd0, 32'd0);
    drive(0, 0, 5'd0, 32'd0, 1, 3'd0, 32'h55);
    idle(2);
    drive(0, 0, 5'd0, 32'd0, 1, 3'd0, 32'h99);
    idle(2);

    // Full-rate dispatch, writeback and commit.
    do_reset(1);
    for (int i = 0; i < 20; i++)
      drive(1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 32'h400 + 32'(4 * i),
            i > 0, 3'((i + 7) % 8), $urandom);
    drive(0, 0, 5'd0, 32'd0, 1, 3'(19 % 8), 32'h77);
    idle(3);

`ifdef ROB_FWD_EN
    // Two writers of r5: youngest wins, ready after its writeback.
    do_reset(1);
    lk_addr = 5'd5;
    drive(1, 1, 5'd1, 32'h500, 0, 3'd0, 32'd0);
    drive(1, 1, 5'd5, 32'h504, 0, 3'd0, 32'd0);
    drive(1, 1, 5'd2, 32'h508, 0, 3'd0, 32'd0);
    drive(1, 1, 5'd5, 32'h50c, 0, 3'd0, 32'd0);
    idle(1);
    drive(0, 0, 5'd0, 32'd0, 1, 3'd3, 32'h7);
    idle(1);
    lk_addr = 5'd0;
    idle(2);
`endif

    // Randomized traffic, including stale and duplicate writebacks.
    do_reset(1);
    for (int i = 0; i < 400; i++) begin
`ifdef ROB_FWD_EN
      lk_addr = 5'($urandom_range(0, 7));
`endif
      drive(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
            32'h1000 + 32'(4 * i), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom);
    end
    idle(2);

    // Reset in the middle of traffic discards everything.
    drive(1, 1, 5'd4, 32'h2000, 0, 3'd0, 32'd0);
    do_reset(1);
    idle(2);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
